cpu_icache: RTL and testbench

- Instruction-cache responder at the far end of the fetch stage's cache request/response interface.
- Accepts one word-aligned fetch address per request and returns the 32-bit instruction word.
- Direct-mapped, read-only. On a miss it refills the whole line from the instruction-memory port, then answers the pending fetch.
- Sits between the fetch stage and the memory/bus interface.

---
 rtl/cpu_icache.sv | 141 ++++++++++++++
 tb/tb_cpu_icache.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_icache.sv
// cpu_icache: direct-mapped, read-only instruction cache.
// Hits answer one cycle after acceptance. A miss refills the whole line
// from the memory port, then answers the pending fetch.
// Optional hit/miss counters are enabled by defining CPU_ICACHE_PERF_EN.
module cpu_icache #(
    parameter int ADDR_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_word,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
`ifdef CPU_ICACHE_PERF_EN
    input  logic [31:0]       mem_rsp_data,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`else
    input  logic [31:0]       mem_rsp_data
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESPOND} state_t;

    state_t            state;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS_PER_LINE];

    // Fields of the fetch that missed, held across the refill.
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [OFF_W-1:0]  miss_off;
    logic [OFF_W-1:0]  beat;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;
    logic              accept;
    logic              unused_byte_bits;

    // Byte-select bits of the fetch address carry no information.
    assign unused_byte_bits = ^req_addr[1:0];

    // Address split and tag compare for the incoming fetch.
    assign req_off = req_addr[OFF_W+1:2];
    assign req_idx = req_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag = req_addr[ADDR_W-1:OFF_W+IDX_W+2];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept  = req_valid && req_ready;

    // Cache controller: lookup, refill sequencing, registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            valid_q       <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_word      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            beat          <= '0;
            miss_tag      <= '0;
            miss_idx      <= '0;
            miss_off      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        if (hit) begin
                            rsp_valid <= 1'b1;
                            rsp_word  <= data_q[req_idx][req_off];
                        end else begin
                            miss_tag      <= req_tag;
                            miss_idx      <= req_idx;
                            miss_off      <= req_off;
                            req_ready     <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                            state         <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rsp_valid) begin
                        data_q[miss_idx][beat] <= mem_rsp_data;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            valid_q[miss_idx] <= 1'b1;
                            tag_q[miss_idx]   <= miss_tag;
                            state             <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    // Line is complete here, so the pending word reads from storage.
                    rsp_valid <= 1'b1;
                    rsp_word  <= data_q[miss_idx][miss_off];
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_ICACHE_PERF_EN
    // Hit/miss counters, counted at acceptance; wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state == IDLE && accept) begin
            if (hit) perf_hits   <= perf_hits + 32'd1;
            else     perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_icache.sv
// tb_cpu_icache: directed bench for cpu_icache. A table of back-to-back
// hit vectors plus hand-written miss, stall, conflict and reset sequences.
module tb_cpu_icache;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_word;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
`ifdef CPU_ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } vec_t;

    vec_t hv [5];

    cpu_icache dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_word      (rsp_word),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
`ifdef CPU_ICACHE_PERF_EN
        .mem_rsp_data  (mem_rsp_data),
        .perf_hits     (perf_hits),
        .perf_misses   (perf_misses)
`else
        .mem_rsp_data  (mem_rsp_data)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_word"}, rsp_word, 0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    endtask

    // Miss on addr; memory returns base+0..base+3 after rdy_dly cycles of
    // mem_req_ready=0 and with gap idle cycles ahead of every beat.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base,
                           input int rdy_dly, input int gap);
        logic [31:0] a;
        logic [31:0] line;
        int lat;
        a    = addr;
        line = addr & ~32'hF;
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        check("miss_mem_req_valid", mem_req_valid, 1);
        check("miss_mem_req_addr", mem_req_addr, line);
        check("miss_req_ready", req_ready, 0);
        check("miss_rsp_early", rsp_valid, 0);
        lat = 0;
        repeat (rdy_dly) begin
            step();
            lat++;
            check("stall_mem_req_valid", mem_req_valid, 1);
            check("stall_mem_req_addr", mem_req_addr, line);
        end
        mem_req_ready = 1'b1;
        step();
        lat++;
        mem_req_ready = 1'b0;
        check("refill_mem_req_valid", mem_req_valid, 0);
        for (int b = 0; b < 4; b++) begin
            repeat (gap) begin
                step();
                lat++;
                check("gap_rsp_valid", rsp_valid, 0);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(b);
            step();
            lat++;
            mem_rsp_valid = 1'b0;
            check("refill_req_ready", req_ready, 0);
            check("refill_rsp_valid", rsp_valid, 0);
        end
        step();
        lat++;
        check("miss_rsp_valid", rsp_valid, 1);
        check("miss_rsp_word", rsp_word, base + 32'(a[3:2]));
        check("miss_latency", lat, 6 + rdy_dly + 4 * gap);
        check("miss_ready_back", req_ready, 1);
        step();
        check("miss_rsp_once", rsp_valid, 0);
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        check("hit_rsp_valid", rsp_valid, 1);
        check("hit_rsp_word", rsp_word, exp);
        check("hit_no_mem_req", mem_req_valid, 0);
        step();
        check("hit_rsp_once", rsp_valid, 0);
    endtask

    initial begin
        hv[0] = '{32'h104, 32'hA1};
        hv[1] = '{32'h108, 32'hA2};
        hv[2] = '{32'h10C, 32'hA3};
        hv[3] = '{32'h100, 32'hA0};
        hv[4] = '{32'h10E, 32'hA3};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        step();
        step();
        check_reset_outputs("reset");
`ifdef CPU_ICACHE_PERF_EN
        check("reset_perf_hits", perf_hits, 0);
        check("reset_perf_misses", perf_misses, 0);
`endif
        reset = 1'b0;
        step();

        // Cold miss on 0x100.
        do_miss(32'h100, 32'hA0, 0, 0);

        // Back-to-back hits on the refilled line.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = hv[i].addr;
            step();
            check("b2b_rsp_valid", rsp_valid, 1);
            check("b2b_rsp_word", rsp_word, hv[i].word);
            check("b2b_mem_req_valid", mem_req_valid, 0);
            check("b2b_req_ready", req_ready, 1);
        end
        req_valid = 1'b0;
        step();
        check("b2b_end_valid", rsp_valid, 0);
        check("b2b_word_hold", rsp_word, 32'hA3);
`ifdef CPU_ICACHE_PERF_EN
        check("perf_misses", perf_misses, 1);
        check("perf_hits", perf_hits, 5);
`endif

        // Conflicting tag at the same index evicts and is evicted.
        do_miss(32'h500, 32'hB0, 0, 0);
        do_hit(32'h500, 32'hB0);
        do_miss(32'h100, 32'hC0, 0, 0);
        do_hit(32'h104, 32'hC1);
        do_miss(32'h508, 32'hD0, 0, 0);

        // Memory request backpressure plus gaps between beats.
        do_miss(32'h304, 32'hE0, 5, 2);
        do_hit(32'h30C, 32'hE3);

        // Reset in the middle of a refill of 0x200.
        req_valid = 1'b1;
        req_addr  = 32'h200;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hF0 + 32'(b);
            step();
        end
        reset = 1'b1;
        mem_rsp_data = 32'hF2;
        step();
        check_reset_outputs("midreset");
        reset = 1'b0;
        mem_rsp_data = 32'hF3;
        step();
        mem_rsp_valid = 1'b0;
        check("stale_rsp_valid", rsp_valid, 0);
        check("stale_req_ready", req_ready, 1);
        check("stale_mem_req_valid", mem_req_valid, 0);
        do_miss(32'h208, 32'h90, 0, 0);
        do_hit(32'h200, 32'h90);
        // Lines valid before reset are gone.
        do_miss(32'h304, 32'h70, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
